// File: rtl/riscv_core_reset_pkg.sv
// Shared types and constants for the RISC-V core reset sequencer.
package riscv_core_reset_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR     = 2'd0;
  localparam logic [1:0] CAUSE_SOFT    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Registered output bundle of the sequencer.
  typedef struct packed {
    logic        reset_act;
    logic [31:0] reset_pc;
    logic        core_hold;
    logic        fetch_halt;
    logic        rst_done;
    logic [1:0]  rst_cause;
  } seq_out_t;

  // Boot address chosen by the latched boot select.
  function automatic logic [31:0] boot_pc(input logic        sel,
                                          input logic [31:0] start_addr,
                                          input logic [31:0] alt_addr);
    logic [31:0] pc;
    if (sel) begin
      pc = alt_addr;
    end else begin
      pc = start_addr;
    end
    return pc;
  endfunction

endpackage

// File: rtl/riscv_core_reset_seq.sv
// Reset sequencer: holds the pipeline, drains bus traffic on a soft reset,
// strobes the PC-reset unit with the boot address for one cycle, then
// releases the pipeline. All outputs are registered and depend only on the
// sequencer state, so they are computed from the next state one edge early.
module riscv_core_reset_seq
  import riscv_core_reset_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS = 32'h00001000,
  parameter logic [31:0] ALT_ADDRESS   = 32'h00000000,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_rst_req,
  input  logic        bus_idle,
  input  logic        boot_sel,
  output logic        reset_act,
  output logic [31:0] reset_pc,
  output logic        core_hold,
  output logic        fetch_halt,
  output logic        rst_done,
  output logic [1:0]  rst_cause
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = 16'd0;
  localparam logic [CNT_W-1:0] CNT_ONE    = 16'd1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  // Output values while RST is low: pipeline stalled, fetch blocked.
  localparam seq_out_t OUT_RESET = '{
    reset_act:  1'b0,
    reset_pc:   32'h00000000,
    core_hold:  1'b1,
    fetch_halt: 1'b1,
    rst_done:   1'b0,
    rst_cause:  CAUSE_POR
  };

  rst_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             boot_sel_r, boot_sel_s;
  logic [1:0]       cause_r, cause_s;
  seq_out_t         out_r, out_s;

  // State, counter, latched boot select, cause and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= HOLD;
      cnt_r      <= CNT_ZERO;
      cause_r    <= CAUSE_POR;
      boot_sel_r <= boot_sel;
      out_r      <= OUT_RESET;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cause_r    <= cause_s;
      boot_sel_r <= boot_sel_s;
      out_r      <= out_s;
    end
  end

  // Next-state logic: hold countdown, one-cycle load, run, bounded drain.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    boot_sel_s = boot_sel_r;
    cause_s    = cause_r;
    case (state_r)
      HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s = LOAD;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      LOAD: begin
        state_s = RUN;
        cnt_s   = CNT_ZERO;
      end
      RUN: begin
        if (soft_rst_req) begin
          state_s = DRAIN;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        // Bus idle takes priority over a coincident timeout.
        if (bus_idle) begin
          state_s    = HOLD;
          cnt_s      = CNT_ZERO;
          cause_s    = CAUSE_SOFT;
          boot_sel_s = boot_sel;
        end else if (cnt_r == DRAIN_LAST) begin
          state_s    = HOLD;
          cnt_s      = CNT_ZERO;
          cause_s    = CAUSE_TIMEOUT;
          boot_sel_s = boot_sel;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = HOLD;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the state being entered, registered next edge.
  always_comb begin
    out_s           = OUT_RESET;
    out_s.rst_cause = cause_s;
    case (state_s)
      HOLD: begin
        out_s.core_hold  = 1'b1;
        out_s.fetch_halt = 1'b1;
      end
      LOAD: begin
        out_s.reset_act  = 1'b1;
        out_s.reset_pc   = boot_pc(boot_sel_s, START_ADDRESS, ALT_ADDRESS);
        out_s.core_hold  = 1'b1;
        out_s.fetch_halt = 1'b1;
      end
      RUN: begin
        out_s.core_hold  = 1'b0;
        out_s.fetch_halt = 1'b0;
        // Only LOAD leads into RUN, so this marks the first RUN cycle.
        if (state_r == LOAD) begin
          out_s.rst_done = 1'b1;
        end else begin
          out_s.rst_done = 1'b0;
        end
      end
      DRAIN: begin
        out_s.core_hold  = 1'b0;
        out_s.fetch_halt = 1'b1;
      end
      default: begin
        out_s.core_hold  = 1'b1;
        out_s.fetch_halt = 1'b1;
      end
    endcase
  end

  assign reset_act  = out_r.reset_act;
  assign reset_pc   = out_r.reset_pc;
  assign core_hold  = out_r.core_hold;
  assign fetch_halt = out_r.fetch_halt;
  assign rst_done   = out_r.rst_done;
  assign rst_cause  = out_r.rst_cause;

endmodule

// File: tb/tb_riscv_core_reset_seq.sv
// Self-checking bench for riscv_core_reset_seq: a cycle-level behavioural
// model checked every cycle, plus hand-computed expectations at key cycles.
module tb_riscv_core_reset_seq;

  localparam logic [31:0] START_A = 32'h00001000;
  localparam logic [31:0] ALT_A   = 32'h80000000;
  localparam int          HOLD_N  = 4;
  localparam int          DRAIN_N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_rst_req;
  logic        bus_idle;
  logic        boot_sel;
  logic        reset_act;
  logic [31:0] reset_pc;
  logic        core_hold;
  logic        fetch_halt;
  logic        rst_done;
  logic [1:0]  rst_cause;

  int tests = 0;
  int fails = 0;

  riscv_core_reset_seq #(
    .START_ADDRESS(START_A),
    .ALT_ADDRESS  (ALT_A),
    .HOLD_CYCLES  (HOLD_N),
    .DRAIN_TIMEOUT(DRAIN_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst_req(soft_rst_req),
    .bus_idle    (bus_idle),
    .boot_sel    (boot_sel),
    .reset_act   (reset_act),
    .reset_pc    (reset_pc),
    .core_hold   (core_hold),
    .fetch_halt  (fetch_halt),
    .rst_done    (rst_done),
    .rst_cause   (rst_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=hold,1=load,2=run,3=drain, hold as a countdown.
  int   m_phase     = 0;
  int   m_hold_left = HOLD_N;
  int   m_drain_cyc = 0;
  int   m_cause     = 0;
  logic m_sel       = 1'b0;
  logic m_first     = 1'b0;

  logic        exp_act;
  logic [31:0] exp_pc;
  logic        exp_hold;
  logic        exp_halt;
  logic        exp_done;
  logic [1:0]  exp_cause;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_phase = 0; m_hold_left = HOLD_N; m_cause = 0; m_sel = boot_sel; m_first = 1'b0;
      end else begin
        m_first = 1'b0;
        if (m_phase == 0) begin
          m_hold_left = m_hold_left - 1;
          if (m_hold_left == 0) m_phase = 1;
        end else if (m_phase == 1) begin
          m_phase = 2;
          m_first = 1'b1;
        end else if (m_phase == 2) begin
          if (soft_rst_req) begin
            m_phase = 3;
            m_drain_cyc = 0;
          end
        end else begin
          m_drain_cyc = m_drain_cyc + 1;
          if (bus_idle || m_drain_cyc == DRAIN_N) begin
            m_cause = bus_idle ? 1 : 2;
            m_phase = 0;
            m_hold_left = HOLD_N;
            m_sel = boot_sel;
          end
        end
      end
      exp_act   = (m_phase == 1);
      exp_pc    = (m_phase == 1) ? (m_sel ? ALT_A : START_A) : 32'h00000000;
      exp_hold  = (m_phase <= 1);
      exp_halt  = (m_phase != 2);
      exp_done  = m_first;
      exp_cause = 2'(m_cause);
      #1;
      chk("reset_act",  32'(reset_act),  32'(exp_act));
      chk("reset_pc",   reset_pc,        exp_pc);
      chk("core_hold",  32'(core_hold),  32'(exp_hold));
      chk("fetch_halt", 32'(fetch_halt), 32'(exp_halt));
      chk("rst_done",   32'(rst_done),   32'(exp_done));
      chk("rst_cause",  32'(rst_cause),  32'(exp_cause));
    end
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; soft_rst_req = 1'b0; bus_idle = 1'b0; boot_sel = 1'b0;
    nclk(3);
    chk("por_hold_in_reset", 32'(core_hold), 32'd1);
    chk("por_halt_in_reset", 32'(fetch_halt), 32'd1);
    chk("por_act_in_reset", 32'(reset_act), 32'd0);
    chk("por_cause_in_reset", 32'(rst_cause), 32'd0);

    // Power-on, boot_sel=0: LOAD on cycle 4, RST_DONE on cycle 5.
    rst = 1'b1;
    nclk(3);
    chk("por_hold3_act", 32'(reset_act), 32'd0);
    nclk(1);
    chk("por_load_act", 32'(reset_act), 32'd1);
    chk("por_load_pc", reset_pc, 32'h00001000);
    chk("por_load_hold", 32'(core_hold), 32'd1);
    chk("por_load_halt", 32'(fetch_halt), 32'd1);
    chk("model_pc_load", exp_pc, 32'h00001000);
    nclk(1);
    chk("por_done", 32'(rst_done), 32'd1);
    chk("por_run_hold", 32'(core_hold), 32'd0);
    chk("por_cause", 32'(rst_cause), 32'd0);
    nclk(1);
    chk("por_done_once", 32'(rst_done), 32'd0);

    // Soft reset, bus idle on third DRAIN cycle.
    soft_rst_req = 1'b1;
    nclk(1);
    chk("soft_d1_halt", 32'(fetch_halt), 32'd1);
    chk("soft_d1_hold", 32'(core_hold), 32'd0);
    soft_rst_req = 1'b0;
    nclk(1);
    chk("soft_d2_halt", 32'(fetch_halt), 32'd1);
    nclk(1);
    chk("soft_d3_hold", 32'(core_hold), 32'd0);
    bus_idle = 1'b1;
    nclk(1);
    chk("soft_h1_hold", 32'(core_hold), 32'd1);
    bus_idle = 1'b0;
    nclk(3);
    chk("soft_h4_act", 32'(reset_act), 32'd0);
    nclk(1);
    chk("soft_load_act", 32'(reset_act), 32'd1);
    chk("soft_load_cause", 32'(rst_cause), 32'd1);
    nclk(1);
    chk("soft_done", 32'(rst_done), 32'd1);
    chk("soft_run_act", 32'(reset_act), 32'd0);
    nclk(1);

    // Soft reset with bus never idle: 8 DRAIN cycles, then timeout.
    soft_rst_req = 1'b1;
    nclk(1);
    soft_rst_req = 1'b0;
    nclk(7);
    chk("tmo_d8_hold", 32'(core_hold), 32'd0);
    chk("tmo_d8_halt", 32'(fetch_halt), 32'd1);
    nclk(1);
    chk("tmo_h1_hold", 32'(core_hold), 32'd1);
    nclk(4);
    chk("tmo_load_act", 32'(reset_act), 32'd1);
    chk("tmo_load_cause", 32'(rst_cause), 32'd2);
    chk("model_cause_tmo", 32'(exp_cause), 32'd2);
    nclk(2);

    // RST during DRAIN cycle 2, with boot_sel=1 latched by the reset.
    soft_rst_req = 1'b1;
    nclk(1);
    soft_rst_req = 1'b0;
    nclk(1);
    rst = 1'b0; boot_sel = 1'b1;
    nclk(1);
    chk("abort_hold", 32'(core_hold), 32'd1);
    chk("abort_halt", 32'(fetch_halt), 32'd1);
    chk("abort_cause", 32'(rst_cause), 32'd0);
    rst = 1'b1;
    nclk(3);
    chk("abort_h3_act", 32'(reset_act), 32'd0);
    nclk(1);
    chk("alt_load_act", 32'(reset_act), 32'd1);
    chk("alt_load_pc", reset_pc, 32'h80000000);
    chk("model_pc_alt", exp_pc, 32'h80000000);
    boot_sel = 1'b0;
    nclk(1);
    chk("alt_run_pc", reset_pc, 32'h00000000);
    chk("alt_done", 32'(rst_done), 32'd1);

    // Requests during HOLD and LOAD are ignored.
    rst = 1'b0;
    nclk(1);
    rst = 1'b1;
    nclk(1);
    soft_rst_req = 1'b1;
    nclk(1);
    soft_rst_req = 1'b0;
    nclk(2);
    soft_rst_req = 1'b1;
    chk("ign_load_act", 32'(reset_act), 32'd1);
    nclk(1);
    chk("ign_done", 32'(rst_done), 32'd1);
    soft_rst_req = 1'b0;
    nclk(1);
    chk("ign_no_drain", 32'(fetch_halt), 32'd0);
    nclk(1);
    chk("ign_still_run", 32'(fetch_halt), 32'd0);

    // Request held high through RST_DONE starts a new DRAIN.
    rst = 1'b0;
    nclk(1);
    rst = 1'b1; soft_rst_req = 1'b1;
    nclk(4);
    chk("held_load_act", 32'(reset_act), 32'd1);
    nclk(1);
    chk("held_done", 32'(rst_done), 32'd1);
    chk("held_run_halt", 32'(fetch_halt), 32'd0);
    nclk(1);
    chk("held_drain_halt", 32'(fetch_halt), 32'd1);
    chk("held_drain_hold", 32'(core_hold), 32'd0);
    soft_rst_req = 1'b0; bus_idle = 1'b1;
    nclk(1);
    chk("held_h1_hold", 32'(core_hold), 32'd1);
    bus_idle = 1'b0;
    nclk(3);
    nclk(1);
    chk("held_load_act2", 32'(reset_act), 32'd1);
    chk("held_cause", 32'(rst_cause), 32'd1);
    nclk(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_core_reset_seq.md
# riscv_core_reset_seq

Reset sequencer for the RISC-V core. It holds the pipeline after power-on or a soft-reset request, drains outstanding bus traffic, and issues a single-cycle activation to the core's PC-reset functional unit with the selected boot address. It then releases the pipeline. It sits between the SoC reset/debug logic and the core's reset event unit.

## Interface
- START_ADDRESS, 32'h00001000, primary boot PC.
- ALT_ADDRESS, 32'h00000000, alternate boot PC, used when BOOT_SEL is latched high.
- HOLD_CYCLES, 4, cycles the pipeline is held before PC load. Legal range 1..65535.
- DRAIN_TIMEOUT, 64, maximum DRAIN cycles before a forced reset. Legal range 1..65535.

Ports:
- CLK  in  1  core clock; all state changes on rising edge.
- RST  in  1  synchronous, active-low reset.
- SOFT_RST_REQ  in  1  soft-reset request (level); sampled only in RUN.
- BUS_IDLE  in  1  high when no fetch or load/store transaction is outstanding.
- BOOT_SEL  in  1  boot-address select; latched on every entry to HOLD.
- RESET_ACT  out  1  one-cycle activation strobe to the PC-reset unit.
- RESET_PC  out  32  boot address; 0 whenever RESET_ACT is low.
- CORE_HOLD  out  1  stalls every pipeline stage.
- FETCH_HALT  out  1  blocks new fetch requests.
- RST_DONE  out  1  one-cycle pulse on the first RUN cycle.
- RST_CAUSE  out  2  0 = power-on, 1 = soft, 2 = soft after drain timeout; valid from LOAD onward.

## Operation
- States: HOLD, LOAD, RUN, DRAIN. One 16-bit counter cnt. Registers boot_sel_q and cause_q.
- Outputs are registered. Each output is a function of the current state only (Moore).
- While RST=0:
  - state=HOLD, cnt=0, cause_q=0, boot_sel_q=BOOT_SEL.
  - Outputs: CORE_HOLD=1, FETCH_HALT=1, RESET_ACT=0, RESET_PC=0, RST_DONE=0, RST_CAUSE=0.
- HOLD:
  - CORE_HOLD=1, FETCH_HALT=1.
  - cnt increments each cycle. When cnt==HOLD_CYCLES-1, go to LOAD and clear cnt.
- LOAD (exactly 1 cycle):
  - RESET_ACT=1, RESET_PC = boot_sel_q ? ALT_ADDRESS : START_ADDRESS, CORE_HOLD=1.
  - Next state is always RUN.
- RUN:
  - CORE_HOLD=0, FETCH_HALT=0.
  - RST_DONE=1 only on the first RUN cycle.
  - SOFT_RST_REQ=1 sampled: go to DRAIN, clear cnt.
- DRAIN:
  - CORE_HOLD=0 so in-flight instructions retire; FETCH_HALT=1.
  - BUS_IDLE=1 sampled: go to HOLD with cause_q=1.
  - Otherwise cnt increments. When cnt==DRAIN_TIMEOUT-1, go to HOLD with cause_q=2.
  - If both conditions hold in the same cycle, BUS_IDLE wins (cause 1).
  - On entry to HOLD, clear cnt and set boot_sel_q=BOOT_SEL.
- SOFT_RST_REQ is ignored in HOLD, LOAD and DRAIN. A request that is still high on the first RUN cycle starts a new DRAIN. Requesters must deassert the request on RST_DONE.
- RST=0 in any state aborts immediately to the reset values. A partial drain is not completed.

## Timing
- Power-on: the first cycle with RST=1 is HOLD cycle 1.
  - LOAD follows HOLD_CYCLES cycles after that first cycle.
  - RUN and the RST_DONE pulse come 1 cycle after LOAD.
  - Total: HOLD_CYCLES+1 cycles from reset release to RST_DONE.
- Soft reset: request in RUN cycle t.
  - DRAIN occupies t+1 through t+k, where k = cycles until BUS_IDLE is sampled, at most DRAIN_TIMEOUT.
  - HOLD_CYCLES cycles of HOLD follow, then LOAD, then RUN.
- RESET_ACT is high for exactly one cycle per sequence. It is never high outside LOAD.
- CORE_HOLD and FETCH_HALT are both 1 on the cycle RESET_ACT=1.

## Structure
- Package riscv_core_reset_pkg holds:
  - the state enum (HOLD=2'd0, LOAD=2'd1, RUN=2'd2, DRAIN=2'd3);
  - cause constants (CAUSE_POR=2'd0, CAUSE_SOFT=2'd1, CAUSE_TIMEOUT=2'd2);
  - CNT_W=16.
- No sub-module is required. Optionally, riscv_core_reset_t is instantiated inside, driven by RESET_ACT, with r_pc_D/r_pc_WE exported. The default build keeps it external.

## Test plan
- Power-on, HOLD_CYCLES=4, BOOT_SEL=0: release RST at cycle 0 -> RESET_ACT=1 with RESET_PC=32'h00001000 at cycle 4; RST_DONE and CORE_HOLD=0 at cycle 5; RST_CAUSE=0.
- Power-on with BOOT_SEL=1, ALT_ADDRESS=32'h80000000 -> RESET_PC=32'h80000000 during LOAD, and 0 on every other cycle.
- Soft reset with BUS_IDLE rising 3 cycles after entering DRAIN:
  - FETCH_HALT=1 and CORE_HOLD=0 for 3 DRAIN cycles;
  - then 4 HOLD cycles, then LOAD;
  - RST_CAUSE=1; exactly one RESET_ACT pulse.
- Soft reset with BUS_IDLE stuck low, DRAIN_TIMEOUT=8 -> exactly 8 DRAIN cycles, then HOLD; RST_CAUSE=2.
- RST=0 asserted on DRAIN cycle 2 -> next cycle shows HOLD reset values, cnt=0, RST_CAUSE=0; after release, RESET_ACT appears at cycle HOLD_CYCLES.
- SOFT_RST_REQ pulsed during HOLD and during LOAD -> no extra DRAIN. The request held high through RST_DONE -> DRAIN begins on the cycle after the first RUN cycle.
